// File: rtl/wave_capture_pkg.sv
// Shared definitions for the waveform capture path and the display block.
// Holds the write-FSM state encoding and the default frame geometry.
// Ports: none (package).
package wave_capture_pkg;

    localparam int SAMPLE_W           = 16;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 1 << DEFAULT_ADDR_WIDTH;
    localparam int DEFAULT_TIMEOUT    = 1024;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READY   = 2'd2
    } wc_state_t;

endpackage

// File: rtl/wave_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port.
// Latency: read data appears one clock after rd_addr is sampled.
// Backpressure: none; both ports accept an access every cycle.
// Ports: clk; wr_en/wr_addr/wr_data (write); rd_addr/rd_data (read).
module wave_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // No reset on the array or the read register so the tools can map
    // this onto block RAM with its built-in output register.
    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/wave_capture.sv
// Captures the audio sample stream into a ping-pong buffer for a waveform display.
// Latency: sample written on its strobe edge; read_data is 1 cycle after read_addr.
// Backpressure: none; samples arriving while a full frame waits for a swap are dropped.
// Ports: clk, reset (async, active low); sample_valid/sample_in (sample stream);
//        swap_req (display bank exchange); read_addr/read_data (front-bank read);
//        frame_ready, front_bank, forced_trigger (status).
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [SAMPLE_W-1:0]   sample_in,
    input  logic                  swap_req,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [SAMPLE_W-1:0]   read_data,
    output logic                  frame_ready,
    output logic                  front_bank,
    output logic                  forced_trigger
);

    localparam logic [15:0]           TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST     = {ADDR_WIDTH{1'b1}};

    wc_state_t             state, state_nxt;
    logic [ADDR_WIDTH-1:0] wr_idx, wr_idx_nxt;
    logic [15:0]           wait_cnt, wait_cnt_nxt;
    logic                  prev_neg;
    logic                  trig_forced, trig_forced_nxt;
    logic                  frame_ready_nxt;
    logic                  front_bank_nxt;
    logic                  forced_trigger_nxt;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_widx;
    logic [SAMPLE_W-1:0]   ram_q;
    logic                  rd_ok;
    logic                  rising;

    // prev_neg holds the sign of the last accepted sample, so a rising
    // crossing is "last was negative, this one is not".
    assign rising = prev_neg & ~sample_in[SAMPLE_W-1];

    always_comb begin
        state_nxt          = state;
        wr_idx_nxt         = wr_idx;
        wait_cnt_nxt       = wait_cnt;
        trig_forced_nxt    = trig_forced;
        frame_ready_nxt    = frame_ready;
        front_bank_nxt     = front_bank;
        forced_trigger_nxt = forced_trigger;
        ram_we             = 1'b0;
        ram_widx           = wr_idx;

        case (state)
            ST_ARMED: begin
                if (sample_valid) begin
                    // A crossing wins over the timeout when both happen on
                    // the same sample, so the frame is not flagged as forced.
                    if (rising || (wait_cnt == TIMEOUT_LAST)) begin
                        ram_we          = 1'b1;
                        ram_widx        = '0;
                        wr_idx_nxt      = IDX_ONE;
                        trig_forced_nxt = ~rising;
                        wait_cnt_nxt    = '0;
                        state_nxt       = ST_CAPTURE;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 16'd1;
                    end
                end
            end

            ST_CAPTURE: begin
                if (sample_valid) begin
                    ram_we     = 1'b1;
                    wr_idx_nxt = wr_idx + IDX_ONE;
                    if (wr_idx == IDX_LAST) begin
                        frame_ready_nxt = 1'b1;
                        state_nxt       = ST_READY;
                    end
                end
            end

            ST_READY: begin
                // Samples here are discarded; a swap re-arms the trigger.
                if (swap_req) begin
                    front_bank_nxt     = ~front_bank;
                    forced_trigger_nxt = trig_forced;
                    frame_ready_nxt    = 1'b0;
                    state_nxt          = ST_ARMED;
                end
            end

            default: begin
                state_nxt = ST_ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_ARMED;
            wr_idx         <= '0;
            wait_cnt       <= '0;
            prev_neg       <= 1'b0;
            trig_forced    <= 1'b0;
            frame_ready    <= 1'b0;
            front_bank     <= 1'b0;
            forced_trigger <= 1'b0;
            rd_ok          <= 1'b0;
        end else begin
            state          <= state_nxt;
            wr_idx         <= wr_idx_nxt;
            wait_cnt       <= wait_cnt_nxt;
            trig_forced    <= trig_forced_nxt;
            frame_ready    <= frame_ready_nxt;
            front_bank     <= front_bank_nxt;
            forced_trigger <= forced_trigger_nxt;
            rd_ok          <= 1'b1;
            if (sample_valid) begin
                prev_neg <= sample_in[SAMPLE_W-1];
            end
        end
    end

    wave_ram #(
        .DATA_W (SAMPLE_W),
        .ADDR_W (ADDR_WIDTH + 1)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr ({~front_bank, ram_widx}),
        .wr_data (sample_in),
        .rd_addr ({front_bank, read_addr}),
        .rd_data (ram_q)
    );

    // The RAM read register carries no reset; rd_ok forces read_data to zero
    // from reset assertion until the first read after release has landed.
    assign read_data = rd_ok ? ram_q : '0;

endmodule

// File: tb/tb_wave_capture.sv
module tb_wave_capture;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_valid;
    logic [15:0]   sample_in;
    logic          swap_req;
    logic [AW-1:0] read_addr;
    logic [15:0]   read_data;
    logic          frame_ready;
    logic          front_bank;
    logic          forced_trigger;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    wave_capture #(.ADDR_WIDTH(AW), .TIMEOUT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_in      (sample_in),
        .swap_req       (swap_req),
        .read_addr      (read_addr),
        .read_data      (read_data),
        .frame_ready    (frame_ready),
        .front_bank     (front_bank),
        .forced_trigger (forced_trigger)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock of stimulus, applied at a falling edge; returns at the next
    // falling edge with the strobes dropped again.
    task automatic cyc(input logic v, input int s, input logic sw);
        sample_valid = v;
        sample_in    = s[15:0];
        swap_req     = sw;
        @(negedge clk);
        sample_valid = 1'b0;
        swap_req     = 1'b0;
    endtask

    // Capture a sample the bench expects to land in the frame.
    task automatic cap(input int s);
        exp_q.push_back(s & 16'hffff);
        cyc(1'b1, s, 1'b0);
    endtask

    task automatic read_front(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            read_addr = AW'(i);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check_eq({tag, "_underflow"}, 1, 0);
            end else begin
                check_eq(tag, int'(read_data), exp_q.pop_front());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        swap_req     = 1'b0;
        read_addr    = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_front",  int'(front_bank), 0);
        check_eq("rst_ready",  int'(frame_ready), 0);
        check_eq("rst_forced", int'(forced_trigger), 0);
        check_eq("rst_rdata",  int'(read_data), 0);
        reset = 1'b1;
        @(negedge clk);

        // Crossing trigger: -5, -1, then 0..7 captured, 8 dropped.
        cyc(1'b1, -5, 1'b0);
        cyc(1'b1, -1, 1'b0);
        for (int v = 0; v < DEPTH; v++) begin
            cap(v);
            if (v == DEPTH - 2) check_eq("xing_ready_early", int'(frame_ready), 0);
        end
        check_eq("xing_ready", int'(frame_ready), 1);
        cyc(1'b1, 8, 1'b0);
        check_eq("xing_front_pre", int'(front_bank), 0);
        cyc(1'b0, 0, 1'b1);
        check_eq("xing_front",  int'(front_bank), 1);
        check_eq("xing_forced", int'(forced_trigger), 0);
        check_eq("xing_ready_clr", int'(frame_ready), 0);
        read_front("xing_frame");

        // Timeout: constant +100, trigger on the 4th, ignored swaps.
        for (int i = 0; i < 11; i++) begin
            if (i >= 3) exp_q.push_back(100);
            if (i == 10) begin
                cyc(1'b1, 100, 1'b1);
            end else begin
                cyc(1'b1, 100, 1'b0);
            end
            if (i == 6) begin
                cyc(1'b0, 0, 1'b1);
                check_eq("early_swap_front", int'(front_bank), 1);
                check_eq("early_swap_ready", int'(frame_ready), 0);
            end
            if (i == 9) check_eq("tmo_ready_early", int'(frame_ready), 0);
        end
        check_eq("simul_swap_ready", int'(frame_ready), 1);
        check_eq("simul_swap_front", int'(front_bank), 1);
        cyc(1'b0, 0, 1'b0);
        check_eq("simul_swap_hold", int'(front_bank), 1);
        read_addr = '0;
        cyc(1'b0, 0, 1'b1);
        check_eq("swap_cycle_old", int'(read_data), 0);
        @(negedge clk);
        check_eq("swap_next_new", int'(read_data), 100);
        check_eq("tmo_front",  int'(front_bank), 0);
        check_eq("tmo_forced", int'(forced_trigger), 1);
        read_front("tmo_frame");

        // Dropped samples in READY; swap cycle carries a would-be crossing.
        cyc(1'b1, -2, 1'b0);
        for (int v = 10; v < 10 + DEPTH; v++) cap(v);
        check_eq("drop_ready", int'(frame_ready), 1);
        cyc(1'b1, 50, 1'b0);
        cyc(1'b1, 60, 1'b0);
        cyc(1'b1, -9, 1'b0);
        sample_valid = 1'b1;
        cyc(1'b1, 30, 1'b1);
        check_eq("drop_front",  int'(front_bank), 1);
        check_eq("drop_forced", int'(forced_trigger), 0);
        read_front("drop_frame");
        cyc(1'b1, -1, 1'b0);
        for (int v = 20; v < 20 + DEPTH; v++) begin
            cap(v);
            if (v == 20 + DEPTH - 2) check_eq("rearm_ready_early", int'(frame_ready), 0);
        end
        check_eq("rearm_ready", int'(frame_ready), 1);
        cyc(1'b0, 0, 1'b1);
        check_eq("rearm_front", int'(front_bank), 0);
        read_front("rearm_frame");

        // Back-to-back strobes: ramp -3..16 on 20 consecutive cycles.
        for (int v = -3; v <= 16; v++) begin
            if (v >= 0 && v < DEPTH) exp_q.push_back(v);
            cyc(1'b1, v, 1'b0);
        end
        check_eq("b2b_ready", int'(frame_ready), 1);
        cyc(1'b0, 0, 1'b1);
        check_eq("b2b_front",  int'(front_bank), 1);
        check_eq("b2b_forced", int'(forced_trigger), 0);
        read_front("b2b_frame");

        // Async reset in the middle of a capture.
        read_addr = AW'(1);
        cyc(1'b1, -1, 1'b0);
        cyc(1'b1, 5, 1'b0);
        cyc(1'b1, 6, 1'b0);
        check_eq("pre_rst_rdata", int'(read_data), 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_front",  int'(front_bank), 0);
        check_eq("arst_ready",  int'(frame_ready), 0);
        check_eq("arst_forced", int'(forced_trigger), 0);
        check_eq("arst_rdata",  int'(read_data), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        cyc(1'b1, -1, 1'b0);
        for (int v = 40; v < 40 + DEPTH; v++) begin
            cap(v);
            if (v == 40 + DEPTH - 2) check_eq("post_rst_ready_early", int'(frame_ready), 0);
        end
        check_eq("post_rst_ready", int'(frame_ready), 1);
        cyc(1'b0, 0, 1'b1);
        check_eq("post_rst_front", int'(front_bank), 1);
        read_front("post_rst_frame");
        check_eq("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
